dac_spi_multi: RTL

Parametrised multi-channel serial DAC driver. It generates its own chip-select, serial clock, data and LDAC signals, so the front-end does not need an external cs/sck/bit-counter generator. Each request loads up to N_CH data words, shifts each enabled channel MSB-first on a shared sck/sdi bus with one chip-select per channel, then pulses LDAC. The block sits between the classification result logic and the external DAC devices.

---
 rtl/dac_spi_multi_if.sv | 32 +++
 rtl/dac_spi_multi.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dac_spi_multi_if.sv
// Request and serial-bus signals of the multi-channel DAC driver.
//   enable, start, data_in, ch_mask : request side, driven by the front-end
//   busy, done                      : request status, driven by the driver
//   cs_n, sck, sdi, ldac_n          : serial DAC bus, driven by the driver
// Handshake: a request is taken on a clock edge where start=1 and enable=1
// while the driver is idle (or in its done cycle); data_in and ch_mask are
// captured on that edge. done is a one-cycle completion pulse.
interface dac_spi_multi_if #(
  parameter int DATA_W = 16,
  parameter int N_CH   = 4
);
  logic                     enable;
  logic                     start;
  logic [N_CH*DATA_W-1:0]   data_in;
  logic [N_CH-1:0]          ch_mask;
  logic                     busy;
  logic                     done;
  logic [N_CH-1:0]          cs_n;
  logic                     sck;
  logic                     sdi;
  logic                     ldac_n;

  modport master (
    output enable, start, data_in, ch_mask,
    input  busy, done, cs_n, sck, sdi, ldac_n
  );

  modport slave (
    input  enable, start, data_in, ch_mask,
    output busy, done, cs_n, sck, sdi, ldac_n
  );
endinterface

// File: rtl/dac_spi_multi.sv
// Multi-channel serial DAC driver. Shifts each enabled channel's word
// MSB-first on a shared sck/sdi bus with one cs_n per channel, then strobes
// ldac_n (after every frame, or once after the last frame in LDAC_MODE=1).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : dac_spi_multi_if slave (request, status, serial bus)
//   state_dbg : current FSM state (IDLE=0 SHIFT=1 GAP=2 LDAC=3 FIN=4)
module dac_spi_multi #(
  parameter int DATA_W    = 16,
  parameter int N_CH      = 4,
  parameter int SCK_DIV   = 2,
  parameter int T_CS_LD   = 2,
  parameter int T_LDAC    = 5,
  parameter int LDAC_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  dac_spi_multi_if.slave   bus,
  output logic [2:0]       state_dbg
);
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PW   = $clog2(2*SCK_DIV) + 1;
  localparam int BW   = $clog2(DATA_W) + 1;
  localparam int TMAX = (T_CS_LD > T_LDAC) ? T_CS_LD : T_LDAC;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    LDAC  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t                  state;
  logic [CW-1:0]           ch;
  logic [N_CH*DATA_W-1:0]  data_q;
  logic [N_CH-1:0]         mask_q;
  logic [DATA_W-1:0]       shreg;
  logic [PW-1:0]           pcnt;
  logic [BW-1:0]           bitn;
  logic [TW-1:0]           tcnt;

  // Lowest enabled channel with index >= lo; MSB of the result is "found".
  function automatic logic [CW:0] pick(input logic [N_CH-1:0] m, input int lo);
    logic [CW:0] r;
    r = '0;
    for (int c = N_CH-1; c >= 0; c--)
      if (m[c] && c >= lo) r = {1'b1, CW'(c)};
    return r;
  endfunction

  logic                    accept;
  logic                    gap_end;
  logic                    ldac_end;
  logic [CW:0]             nx;
  logic [N_CH*DATA_W-1:0]  src_data;
  logic [DATA_W-1:0]       nx_word;
  logic                    go_frame;

  // The done cycle also accepts, so back-to-back requests have no dead cycle.
  // On accept the next frame comes straight from the bus inputs; otherwise
  // it is the next enabled channel above the current one.
  always_comb begin
    accept   = (state == IDLE || state == FIN) && bus.enable && bus.start;
    gap_end  = (state == GAP)  && (tcnt == TW'(T_CS_LD - 1));
    ldac_end = (state == LDAC) && (tcnt == TW'(T_LDAC - 1));
    src_data = accept ? bus.data_in : data_q;
    nx       = accept ? pick(bus.ch_mask, 0) : pick(mask_q, int'(ch) + 1);
    nx_word  = src_data[int'(nx[CW-1:0])*DATA_W +: DATA_W];
    go_frame = nx[CW] && (accept ||
               (gap_end  && LDAC_MODE == 1) ||
               (ldac_end && LDAC_MODE == 0));
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      state      <= IDLE;
      ch         <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      shreg      <= '0;
      pcnt       <= '0;
      bitn       <= '0;
      tcnt       <= '0;
      bus.cs_n   <= '1;
      bus.sck    <= 1'b0;
      bus.sdi    <= 1'b0;
      bus.ldac_n <= 1'b1;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        data_q <= bus.data_in;
        mask_q <= bus.ch_mask;
      end
      if (go_frame) begin
        // Start a frame: cs_n low, MSB on sdi, sck low for the first half-bit.
        state      <= SHIFT;
        ch         <= nx[CW-1:0];
        bus.cs_n   <= ~(N_CH'(1) << nx[CW-1:0]);
        bus.sdi    <= nx_word[DATA_W-1];
        shreg      <= nx_word << 1;
        bus.sck    <= 1'b0;
        bus.ldac_n <= 1'b1;
        bus.busy   <= 1'b1;
        pcnt       <= '0;
        bitn       <= '0;
      end else begin
        case (state)
          IDLE, FIN: begin
            // Only an accept with an empty mask reaches here as a request.
            if (accept) begin
              state    <= FIN;
              bus.done <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          SHIFT: begin
            if (pcnt == PW'(2*SCK_DIV - 1)) begin
              pcnt    <= '0;
              bus.sck <= 1'b0;
              if (bitn == BW'(DATA_W - 1)) begin
                state    <= GAP;
                bus.cs_n <= '1;
                bus.sdi  <= 1'b0;
                tcnt     <= '0;
              end else begin
                bitn    <= bitn + 1'b1;
                bus.sdi <= shreg[DATA_W-1];
                shreg   <= shreg << 1;
              end
            end else begin
              pcnt    <= pcnt + 1'b1;
              bus.sck <= (pcnt >= PW'(SCK_DIV - 1));
            end
          end
          GAP: begin
            if (gap_end) begin
              state      <= LDAC;
              bus.ldac_n <= 1'b0;
              tcnt       <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          LDAC: begin
            if (ldac_end) begin
              state      <= FIN;
              bus.ldac_n <= 1'b1;
              bus.done   <= 1'b1;
              bus.busy   <= 1'b0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign state_dbg = state;
endmodule
